wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  RV32 writeback stage; sits between the memory stage / data memory and the register file.
//  Takes one retiring op, waits for load data when needed, aligns and extends it, and selects the result.
//  Drives a one-cycle registered write (regwrite_o/rd_o/wd_o) into the register file.
//  The stage stalls upstream on a pending load and flags load timeouts and misaligned loads.
// PARAMETERS
//  LOAD_TIMEOUT  16  max cycles waited in LOAD_WAIT for dmem_rvalid_i before abort; legal range 1..255
// PORTS
//  clk_i          in   1   clock, all state on rising edge
//  reset_i        in   1   asynchronous, active-low reset (0 = reset)
//  flush_i        in   1   synchronous kill of the held op / pending write
//  valid_i        in   1   MEM stage presents an op
//  ready_o        out  1   stage accepts an op this cycle
//  regwrite_i     in   1   op writes rd
//  rd_i           in   5   destination register
//  wb_sel_i       in   2   00 ALU, 01 LOAD, 10 PC+4, 11 illegal
//  alu_result_i   in   32  ALU result; its [1:0] is the load byte offset
//  pc_plus4_i     in   32  link value for JAL/JALR
//  funct3_i       in   3   load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  dmem_rvalid_i  in   1   load data valid
//  dmem_rdata_i   in   32  raw 32-bit word from data memory
//  regwrite_o     out  1   register-file write enable (one-cycle pulse)
//  rd_o           out  5   register-file write address
//  wd_o           out  32  register-file write data
//  err_o          out  1   sticky error: timeout, misaligned load, illegal wb_sel/funct3
// BEHAVIOUR
//  Reset (reset_i=0, async): state=IDLE, regwrite_o=0, rd_o=0, wd_o=0, err_o=0, timer=0; ready_o=1 after release.
//  States: IDLE, LOAD_WAIT, WRITE. ready_o = (state != LOAD_WAIT) && !flush_i.
//  Accept = valid_i && ready_o at a rising edge. The op is latched at that edge.
//  Non-load accept (wb_sel 00/10): next state WRITE.
//   - regwrite_o = regwrite_i && (rd_i != 0) is high for exactly the cycle after accept.
//   - wd_o = alu_result_i or pc_plus4_i.
//  Load accept (wb_sel 01): next state LOAD_WAIT; timer cleared.
//  LOAD_WAIT, on each edge:
//   - dmem_rvalid_i=1: latch aligned data, go to WRITE.
//   - otherwise timer++. When timer reaches LOAD_TIMEOUT-1 with no rvalid: set err_o, go to IDLE, no write.
//   - rvalid sampled on the same edge as that timeout still completes the load (data wins).
//  Load alignment: sh = 8*alu_result_i[1:0], w = dmem_rdata_i >> sh.
//   - LB/LBU: sign- or zero-extend w[7:0]. LH/LHU: sign- or zero-extend w[15:0]. LW: w.
//   - Misaligned if LH/LHU with offset[0]=1 or LW with offset!=0: set err_o, no write, state returns to IDLE when data arrives.
//  WRITE behaves like IDLE for accepts (back-to-back, 1 op/cycle for non-loads).
//  WRITE with no accept: next state IDLE; regwrite_o drops to 0.
//  regwrite_o is never high with rd_o=0. rd_o/wd_o hold their last value when regwrite_o=0.
//  wb_sel 11 or funct3 011/110/111 on a load: set err_o, op is dropped (no write, no wait), state IDLE.
//  flush_i=1 at an edge:
//   - state becomes IDLE, timer clears, regwrite_o=0 in the following cycle, no accept that cycle.
//   - dmem_rvalid_i arriving after the flush is ignored.
//  dmem_rvalid_i outside LOAD_WAIT is ignored.
//  err_o clears only on reset.
//  Reset mid-LOAD_WAIT aborts immediately; no write ever issues for that load.
// TESTING
//  1. ALU op: rd=5, alu=32'h1234_5678, regwrite=1 -> cycle after accept: regwrite_o=1, rd_o=5, wd_o=32'h1234_5678.
//  2. Back-to-back ALU ops to rd=1,2,3 on consecutive cycles -> three consecutive write pulses; ready_o stays 1.
//  3. LB, offset 2, rdata=32'h0080_0000 after 3-cycle wait -> ready_o=0 for 3 cycles, then wd_o=32'hFFFF_FF80.
//     Same with LBU -> wd_o=32'h0000_0080.
//  4. rd=0 with alu=32'hDEAD_BEEF -> regwrite_o stays 0. JAL with pc_plus4=32'h0000_0104, rd=1 -> wd_o=32'h104.
//  5. Load with no rvalid for LOAD_TIMEOUT cycles -> err_o=1, no write, ready_o=1.
//     LH at offset 1 -> err_o=1, no write.
//  6. flush_i asserted while in LOAD_WAIT, rvalid arriving the next cycle -> no write, ready_o=1.
//     reset_i pulsed low mid-WRITE -> regwrite_o=0 immediately.

Source files
------------

// File: rtl/wb_stage.sv
// RV32 writeback stage: retires one op per cycle, waits on load data, aligns/extends it,
// and issues a registered one-cycle register-file write.
module wb_stage #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        regwrite_i,
  input  logic [4:0]  rd_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [2:0]  funct3_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        regwrite_o,
  output logic [4:0]  rd_o,
  output logic [31:0] wd_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, WRITE} state_e;

  localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  timer_q;
  logic        ld_we_q;
  logic [4:0]  ld_rd_q;
  logic [2:0]  ld_f3_q;
  logic [1:0]  ld_off_q;
  logic        regwrite_q;
  logic [4:0]  rd_q;
  logic [31:0] wd_q;
  logic        err_q;

  logic        f3_ok;
  logic [31:0] shifted;
  logic [31:0] ld_data_d;
  logic        misalign_d;

  assign ready_o    = (state_q != LOAD_WAIT) && !flush_i;
  assign regwrite_o = regwrite_q;
  assign rd_o       = rd_q;
  assign wd_o       = wd_q;
  assign err_o      = err_q;

  assign f3_ok   = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                   (funct3_i == 3'b100) || (funct3_i == 3'b101);
  assign shifted = dmem_rdata_i >> {ld_off_q, 3'b000};

  // funct3[2] selects zero-extension, [1:0] the access size
  always_comb begin
    ld_data_d = shifted;
    case (ld_f3_q[1:0])
      2'b00:   ld_data_d = {{24{shifted[7]  & ~ld_f3_q[2]}}, shifted[7:0]};
      2'b01:   ld_data_d = {{16{shifted[15] & ~ld_f3_q[2]}}, shifted[15:0]};
      default: ld_data_d = shifted;
    endcase
  end

  assign misalign_d = ((ld_f3_q[1:0] == 2'b01) && ld_off_q[0]) ||
                      ((ld_f3_q[1:0] == 2'b10) && (ld_off_q != 2'b00));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      ld_we_q    <= 1'b0;
      ld_rd_q    <= '0;
      ld_f3_q    <= '0;
      ld_off_q   <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      regwrite_q <= 1'b0;
      if (flush_i) begin
        state_q <= IDLE;
        timer_q <= '0;
      end else begin
        case (state_q)
          LOAD_WAIT: begin
            // data arriving on the timeout edge still completes the load
            if (dmem_rvalid_i) begin
              if (misalign_d) begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end else begin
                if (ld_we_q) begin
                  regwrite_q <= 1'b1;
                  rd_q       <= ld_rd_q;
                  wd_q       <= ld_data_d;
                end
                state_q <= WRITE;
              end
            end else if (timer_q == TMO_LAST) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              timer_q <= timer_q + 8'd1;
            end
          end
          default: begin
            if (valid_i) begin
              case (wb_sel_i)
                2'b00, 2'b10: begin
                  if (regwrite_i && (rd_i != 5'd0)) begin
                    regwrite_q <= 1'b1;
                    rd_q       <= rd_i;
                    wd_q       <= wb_sel_i[1] ? pc_plus4_i : alu_result_i;
                  end
                  state_q <= WRITE;
                end
                2'b01: begin
                  if (f3_ok) begin
                    ld_we_q  <= regwrite_i && (rd_i != 5'd0);
                    ld_rd_q  <= rd_i;
                    ld_f3_q  <= funct3_i;
                    ld_off_q <= alu_result_i[1:0];
                    timer_q  <= '0;
                    state_q  <= LOAD_WAIT;
                  end else begin
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                  end
                end
                default: begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
                end
              endcase
            end else begin
              state_q <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/JAL writes, load align/extend, timeout, misalign, flush, reset.
module tb_wb_stage;
  localparam int LT = 16;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic        regwrite_i;
  logic [4:0]  rd_i;
  logic [1:0]  wb_sel_i;
  logic [31:0] alu_result_i;
  logic [31:0] pc_plus4_i;
  logic [2:0]  funct3_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        regwrite_o;
  logic [4:0]  rd_o;
  logic [31:0] wd_o;
  logic        err_o;

  int n_run = 0;
  int n_fail = 0;

  wb_stage #(.LOAD_TIMEOUT(LT)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .regwrite_i(regwrite_i), .rd_i(rd_i), .wb_sel_i(wb_sel_i), .alu_result_i(alu_result_i),
    .pc_plus4_i(pc_plus4_i), .funct3_i(funct3_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i), .regwrite_o(regwrite_o), .rd_o(rd_o), .wd_o(wd_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
    valid_i = 1'b1; regwrite_i = rw; rd_i = rd; wb_sel_i = sel;
    alu_result_i = alu; pc_plus4_i = pc4; funct3_i = f3;
    step();
    valid_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b0; #2;
    chk("rst_regwrite", 32'(regwrite_o), 32'd0);
    chk("rst_rd", 32'(rd_o), 32'd0);
    chk("rst_wd", wd_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    step();
    reset_i = 1'b1;
    chk("rst_ready", 32'(ready_o), 32'd1);
  endtask

  task automatic load_data(input logic [31:0] d);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = d;
    step();
    dmem_rvalid_i = 1'b0;
  endtask

  initial begin
    flush_i = 0; valid_i = 0; regwrite_i = 0; rd_i = 0; wb_sel_i = 0; alu_result_i = 0;
    pc_plus4_i = 0; funct3_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    reset_i = 1'b0;
    step();
    do_reset();

    // 1: single ALU write
    issue(1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'h0, 3'b000);
    chk("alu_we", 32'(regwrite_o), 32'd1);
    chk("alu_rd", 32'(rd_o), 32'd5);
    chk("alu_wd", wd_o, 32'h1234_5678);
    step();
    chk("alu_we_drop", 32'(regwrite_o), 32'd0);
    chk("alu_rd_hold", 32'(rd_o), 32'd5);

    // 2: back-to-back ALU ops
    valid_i = 1'b1; regwrite_i = 1'b1; wb_sel_i = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      rd_i = 5'(i); alu_result_i = 32'h100 + 32'(i);
      chk("b2b_ready", 32'(ready_o), 32'd1);
      step();
      chk("b2b_we", 32'(regwrite_o), 32'd1);
      chk("b2b_rd", 32'(rd_o), 32'(i));
      chk("b2b_wd", wd_o, 32'h100 + 32'(i));
    end
    valid_i = 1'b0;
    step();
    chk("b2b_end", 32'(regwrite_o), 32'd0);

    // 3: LB / LBU at offset 2 after 3-cycle wait
    for (int k = 0; k < 2; k++) begin
      issue(1'b1, 5'd7, 2'b01, 32'h1000_0002, 32'h0, (k == 0) ? 3'b000 : 3'b100);
      chk("ld_ready0", 32'(ready_o), 32'd0);
      chk("ld_nowe", 32'(regwrite_o), 32'd0);
      step(); chk("ld_ready1", 32'(ready_o), 32'd0);
      step(); chk("ld_ready2", 32'(ready_o), 32'd0);
      load_data(32'h0080_0000);
      chk("ld_we", 32'(regwrite_o), 32'd1);
      chk("ld_rd", 32'(rd_o), 32'd7);
      chk(k == 0 ? "lb_wd" : "lbu_wd", wd_o, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      chk("ld_ready_after", 32'(ready_o), 32'd1);
      step();
    end

    // LHU offset 2 and LH offset 0, also a 0-wait response
    issue(1'b1, 5'd8, 2'b01, 32'h0000_0002, 32'h0, 3'b101);
    load_data(32'h9ABC_1234);
    chk("lhu_wd", wd_o, 32'h0000_9ABC);
    issue(1'b1, 5'd8, 2'b01, 32'h0000_0000, 32'h0, 3'b001);
    load_data(32'h1234_8001);
    chk("lh_wd", wd_o, 32'hFFFF_8001);

    // 4: rd=0 never writes; rd/wd hold; JAL link value
    issue(1'b1, 5'd0, 2'b00, 32'hDEAD_BEEF, 32'h0, 3'b000);
    chk("x0_we", 32'(regwrite_o), 32'd0);
    chk("x0_wd_hold", wd_o, 32'hFFFF_8001);
    chk("x0_rd_hold", 32'(rd_o), 32'd8);
    issue(1'b1, 5'd1, 2'b10, 32'h5555_5555, 32'h0000_0104, 3'b000);
    chk("jal_we", 32'(regwrite_o), 32'd1);
    chk("jal_wd", wd_o, 32'h0000_0104);
    step();

    // data arriving on the timeout edge still completes
    issue(1'b1, 5'd11, 2'b01, 32'h0, 32'h0, 3'b010);
    for (int i = 0; i < LT - 1; i++) step();
    chk("edge_ready", 32'(ready_o), 32'd0);
    load_data(32'hCAFE_F00D);
    chk("edge_we", 32'(regwrite_o), 32'd1);
    chk("edge_wd", wd_o, 32'hCAFE_F00D);
    chk("edge_err", 32'(err_o), 32'd0);
    step();

    // 5a: timeout
    issue(1'b1, 5'd12, 2'b01, 32'h0, 32'h0, 3'b010);
    for (int i = 0; i < LT - 1; i++) step();
    chk("tmo_err_pre", 32'(err_o), 32'd0);
    chk("tmo_ready_pre", 32'(ready_o), 32'd0);
    step();
    chk("tmo_err", 32'(err_o), 32'd1);
    chk("tmo_we", 32'(regwrite_o), 32'd0);
    chk("tmo_ready", 32'(ready_o), 32'd1);
    load_data(32'h1111_1111);
    chk("tmo_late_rvalid", 32'(regwrite_o), 32'd0);

    // 5b: LH misaligned
    do_reset();
    issue(1'b1, 5'd9, 2'b01, 32'h0000_0001, 32'h0, 3'b001);
    load_data(32'h2222_2222);
    chk("mis_err", 32'(err_o), 32'd1);
    chk("mis_we", 32'(regwrite_o), 32'd0);
    chk("mis_ready", 32'(ready_o), 32'd1);

    // illegal wb_sel dropped
    do_reset();
    issue(1'b1, 5'd3, 2'b11, 32'h0, 32'h0, 3'b000);
    chk("ill_err", 32'(err_o), 32'd1);
    chk("ill_we", 32'(regwrite_o), 32'd0);
    chk("ill_ready", 32'(ready_o), 32'd1);

    // 6a: flush in LOAD_WAIT, rvalid next cycle ignored
    do_reset();
    issue(1'b1, 5'd10, 2'b01, 32'h0, 32'h0, 3'b010);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("fl_we0", 32'(regwrite_o), 32'd0);
    load_data(32'h3333_3333);
    chk("fl_we", 32'(regwrite_o), 32'd0);
    chk("fl_ready", 32'(ready_o), 32'd1);
    chk("fl_err", 32'(err_o), 32'd0);

    // flush blocks accept
    valid_i = 1'b1; flush_i = 1'b1; regwrite_i = 1'b1; rd_i = 5'd6; wb_sel_i = 2'b00;
    #1 chk("fl_ready_low", 32'(ready_o), 32'd0);
    step();
    valid_i = 1'b0; flush_i = 1'b0;
    chk("fl_noaccept", 32'(regwrite_o), 32'd0);

    // 6b: async reset mid-WRITE
    issue(1'b1, 5'd4, 2'b00, 32'hABCD_0123, 32'h0, 3'b000);
    chk("pre_rst_we", 32'(regwrite_o), 32'd1);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
